one_wire_crc_engine: RTL and testbench
======================================

ONE_WIRE_CRC_ENGINE -- requirements
Module: one_wire_crc_engine

Interface
REQ-001 The block SHALL have the parameter CRC_W, default 8, meaning CRC width in bits; legal values are 8 and 16.
REQ-002 The block SHALL have the parameter POLY_R, default 8'h8C, meaning the reflected generator polynomial, CRC_W bits wide (8'h8C for Dallas CRC-8, 16'hA001 for 1-Wire CRC-16).
REQ-003 The block SHALL have the parameter INIT, default 0, meaning the register value loaded at start.
REQ-004 The block SHALL have the parameter XOROUT, default 0, meaning the value XORed onto the register to form crc_out (16'hFFFF for CRC-16/MAXIM).
REQ-005 The block SHALL have the parameter RESIDUE, default 0, meaning the expected raw register value after data plus transmitted CRC (16'hB001 for inverted CRC-16).
REQ-006 The block SHALL have the parameter CNT_W, default 16, meaning the width of the bit counter.
REQ-007 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port start, input, 1 bit: one-cycle request that loads INIT and latches num_bits.
REQ-010 Port num_bits, input, CNT_W bits: number of serial bits to absorb, sampled only when start=1.
REQ-011 Port bit_valid, input, 1 bit: qualifies bit_in for one cycle.
REQ-012 Port bit_in, input, 1 bit: serial data, LSB-first per 1-Wire byte order.
REQ-013 Port abort, input, 1 bit: cancels the calculation in progress.
REQ-014 Port busy, output, 1 bit: high while in RUN.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.
REQ-016 Port crc_out, output, CRC_W bits: raw register XOR XOROUT, held until the next start.
REQ-017 Port crc_ok, output, 1 bit: residue check result, valid while done=1.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and FINISH, and rst_n low SHALL force IDLE.
REQ-019 In IDLE with start=1, the block SHALL load reg=INIT and cnt=num_bits, and SHALL enter FINISH if num_bits=0, otherwise RUN.
REQ-020 In RUN, each cycle with bit_valid=1 SHALL perform fb=reg[0]^bit_in, then reg=(reg>>1)^(fb?POLY_R:0), then cnt=cnt-1.
REQ-021 In RUN, a cycle with bit_valid=0 SHALL hold reg and cnt unchanged; there is no timeout.
REQ-022 The block SHALL go from RUN to FINISH in the cycle that absorbs the bit making cnt reach 0.
REQ-023 FINISH SHALL last exactly one cycle with done=1 and SHALL then return to IDLE, so done occurs one cycle after the last accepted bit.
REQ-024 bit_valid asserted in IDLE or FINISH SHALL be ignored.
REQ-025 start=1 in RUN or FINISH SHALL restart the calculation (reload INIT and num_bits); if FINISH is pre-empted this way, done SHALL still pulse in that cycle.
REQ-026 abort=1 in RUN SHALL return the block to IDLE next cycle with no done pulse and crc_out unchanged; abort has priority over bit_valid.
REQ-027 If start and abort are asserted in the same cycle, start SHALL win.
REQ-028 crc_out SHALL be combinational from reg and XOROUT.
REQ-029 cnt SHALL never wrap; num_bits up to 2^CNT_W-1 SHALL be supported.

Reset
REQ-030 Asynchronous rst_n low SHALL force state=IDLE, reg=0, cnt=0, busy=0, done=0 and crc_ok=0, so that crc_out=XOROUT.
REQ-031 Reset asserted mid-RUN SHALL discard the partial result with no done pulse; the block SHALL resume on the first clk edge after rst_n is released.

Configuration
REQ-032 When the macro ONE_WIRE_CRC_RESIDUE_CHECK_EN is defined, crc_ok SHALL be 1 during done if and only if the raw reg equals RESIDUE.
REQ-033 When the macro ONE_WIRE_CRC_RESIDUE_CHECK_EN is undefined, crc_ok SHALL be the constant 0 and no comparator SHALL be built.

Verification
REQ-034 Scenario: CRC_W=8 defaults, num_bits=56, ROM bytes 02 1C B8 01 00 00 00 sent LSB-first -> done one cycle after the 56th bit, crc_out=8'hA2.
REQ-035 Scenario: same stimulus with num_bits=64 and CRC byte A2 appended, macro defined -> crc_out=8'h00, crc_ok=1; with last bit flipped -> crc_ok=0.
REQ-036 Scenario: CRC_W=16, POLY_R=16'hA001, XOROUT=16'hFFFF, ASCII "123456789" (72 bits) with random bit_valid gaps -> crc_out=16'h44C2.
REQ-037 Scenario: abort after 20 bits, then start with num_bits=0 -> no done for the aborted run; for the new run, done next cycle with crc_out=INIT^XOROUT.
REQ-038 Scenario: rst_n pulsed low mid-RUN asynchronously (between clock edges) -> outputs are at reset values immediately, no done, busy=0.
REQ-039 Scenario: start asserted in the FINISH cycle -> done pulse seen once, new run begins with reg=INIT, busy=1 next cycle.

Source files
------------

// File: rtl/one_wire_crc_engine_if.sv
// -----------------------------------------------------------------------------
// one_wire_crc_engine_if
//
// Bundles the command, serial-bit and result signals of the 1-Wire CRC
// engine.
//   master : the side issuing start/abort and shifting in bits (testbench,
//            bus controller)
//   slave  : the CRC engine itself
//
// Handshake: start, bit_valid and abort are single-cycle qualifiers sampled
// on the rising clk edge. There is no ready/backpressure. While busy=1 the
// engine absorbs bit_in on every cycle where bit_valid=1. done pulses for
// one cycle when the run completes. crc_ok is meaningful only while done=1.
// crc_out holds its value until the next start.
//
// Signals:
//   start     : load INIT and latch num_bits
//   num_bits  : serial bit count for the run (CNT_W bits)
//   bit_valid : qualifies bit_in
//   bit_in    : serial data, LSB-first
//   abort     : cancel the run in progress
//   busy      : engine is absorbing bits
//   done      : one-cycle completion pulse
//   crc_out   : raw register XOR XOROUT (CRC_W bits)
//   crc_ok    : residue check result
// -----------------------------------------------------------------------------
interface one_wire_crc_engine_if #(
    parameter int CRC_W = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_bits;
    logic             bit_valid;
    logic             bit_in;
    logic             abort;
    logic             busy;
    logic             done;
    logic [CRC_W-1:0] crc_out;
    logic             crc_ok;

    modport master (
        output start, num_bits, bit_valid, bit_in, abort,
        input  busy, done, crc_out, crc_ok
    );

    modport slave (
        input  start, num_bits, bit_valid, bit_in, abort,
        output busy, done, crc_out, crc_ok
    );
endinterface

// File: rtl/one_wire_crc_engine.sv
// -----------------------------------------------------------------------------
// one_wire_crc_engine
//
// Bit-serial reflected CRC engine for 1-Wire traffic (Dallas CRC-8 by
// default, 1-Wire CRC-16 with CRC_W=16 / POLY_R=16'hA001).
// The engine absorbs num_bits serial bits, LSB-first, through a right-shifting
// register.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : one_wire_crc_engine_if.slave (start/num_bits/bit_valid/
//               bit_in/abort in; busy/done/crc_out/crc_ok out)
//   dbg_state : current FSM state (0=IDLE, 1=RUN, 2=FINISH)
//
// Optional feature macro: ONE_WIRE_CRC_RESIDUE_CHECK_EN
//   Defined   : crc_ok = (raw register == RESIDUE) during done.
//   Undefined : crc_ok is tied to 0 and no comparator is built.
// -----------------------------------------------------------------------------
module one_wire_crc_engine #(
    parameter int               CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY_R  = 8'h8C,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOROUT  = '0,
    parameter logic [CRC_W-1:0] RESIDUE = '0,
    parameter int               CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    one_wire_crc_engine_if.slave  bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           state;
    logic [CRC_W-1:0] crc_reg;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic             crc_ok_q;

    // One LFSR step for the bit currently on bit_in.
    logic             fb;
    logic [CRC_W-1:0] next_reg;
    always_comb begin
        fb       = crc_reg[0] ^ bus.bit_in;
        next_reg = (crc_reg >> 1) ^ (fb ? POLY_R : '0);
    end

    // Residue result for the two ways a run can reach FINISH:
    // zero-length start (register is INIT) or absorbing the last bit.
    logic ok_on_init;
    logic ok_on_bit;
`ifdef ONE_WIRE_CRC_RESIDUE_CHECK_EN
    always_comb begin
        ok_on_init = (INIT == RESIDUE);
        ok_on_bit  = (next_reg == RESIDUE);
    end
`else
    // Constant 0. RESIDUE appears only so the parameter stays referenced;
    // the expression folds away.
    always_comb begin
        ok_on_init = 1'b0 & (^RESIDUE);
        ok_on_bit  = 1'b0;
    end
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            crc_reg  <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            crc_ok_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            crc_ok_q <= 1'b0;
            // start restarts from any state and wins over abort. A FINISH
            // cycle pre-empted here has already shown done=1.
            if (bus.start) begin
                crc_reg <= INIT;
                cnt     <= bus.num_bits;
                if (bus.num_bits == '0) begin
                    state    <= S_FINISH;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    crc_ok_q <= ok_on_init;
                end else begin
                    state  <= S_RUN;
                    busy_q <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    S_RUN: begin
                        // abort beats bit_valid and leaves crc_reg untouched.
                        if (bus.abort) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else if (bus.bit_valid) begin
                            crc_reg <= next_reg;
                            // cnt is never 0 in RUN, so it cannot wrap here.
                            cnt     <= cnt - CNT_ONE;
                            if (cnt == CNT_ONE) begin
                                state    <= S_FINISH;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                crc_ok_q <= ok_on_bit;
                            end
                        end
                    end
                    S_FINISH: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.crc_ok  = crc_ok_q;
    assign bus.crc_out = crc_reg ^ XOROUT;
    assign dbg_state   = state;

endmodule

// File: tb/tb_one_wire_crc_engine.sv
module tb_one_wire_crc_engine;
    localparam int CNT_W = 16;
`ifdef ONE_WIRE_CRC_RESIDUE_CHECK_EN
    localparam logic OK_EN = 1'b1;
`else
    localparam logic OK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg8;
    logic [1:0] dbg16;

    one_wire_crc_engine_if #(.CRC_W(8),  .CNT_W(CNT_W)) bus8 ();
    one_wire_crc_engine_if #(.CRC_W(16), .CNT_W(CNT_W)) bus16 ();

    one_wire_crc_engine #(
        .CRC_W(8), .POLY_R(8'h8C), .INIT(8'h00), .XOROUT(8'h00),
        .RESIDUE(8'h00), .CNT_W(CNT_W)
    ) u_crc8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8), .dbg_state(dbg8)
    );

    one_wire_crc_engine #(
        .CRC_W(16), .POLY_R(16'hA001), .INIT(16'h0000), .XOROUT(16'hFFFF),
        .RESIDUE(16'hB001), .CNT_W(CNT_W)
    ) u_crc16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16), .dbg_state(dbg16)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    logic [7:0] rom [0:7];
    logic [7:0] str [0:10];

    function automatic logic [15:0] crc_step(input logic [15:0] r, input logic b,
                                             input logic [15:0] poly);
        logic fb;
        fb = r[0] ^ b;
        crc_step = (r >> 1) ^ (fb ? poly : 16'h0000);
    endfunction

    // ---------------- drivers ----------------
    task automatic start8(input logic [15:0] n);
        bus8.start = 1'b1; bus8.num_bits = n;
        @(posedge clk); #1;
        bus8.start = 1'b0;
    endtask

    task automatic send8(input logic b);
        bus8.bit_valid = 1'b1; bus8.bit_in = b;
        @(posedge clk); #1;
        bus8.bit_valid = 1'b0; bus8.bit_in = 1'b0;
    endtask

    task automatic start16(input logic [15:0] n);
        bus16.start = 1'b1; bus16.num_bits = n;
        @(posedge clk); #1;
        bus16.start = 1'b0;
    endtask

    task automatic send16(input logic b, input int gap);
        repeat (gap) begin
            bus16.bit_valid = 1'b0; bus16.bit_in = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus16.bit_valid = 1'b1; bus16.bit_in = b;
        @(posedge clk); #1;
        bus16.bit_valid = 1'b0; bus16.bit_in = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus8.start = 0; bus8.num_bits = '0; bus8.bit_valid = 0; bus8.bit_in = 0; bus8.abort = 0;
        bus16.start = 0; bus16.num_bits = '0; bus16.bit_valid = 0; bus16.bit_in = 0; bus16.abort = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dbg8 !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg8); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus8.busy); end
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus8.done); end
        checks++; if (bus8.crc_ok !== 1'b0) begin errors++; $display("FAIL reset_crc_ok got=%b exp=0", bus8.crc_ok); end
        checks++; if (bus8.crc_out !== 8'h00) begin errors++; $display("FAIL reset_crc8 got=%h exp=00", bus8.crc_out); end
        checks++; if (bus16.crc_out !== 16'hFFFF) begin errors++; $display("FAIL reset_crc16 got=%h exp=ffff", bus16.crc_out); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rom_crc8();
        logic [15:0] e;
        exp_q.push_back(16'h00A2);
        start8(16'd56);
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL rom_busy got=%b exp=1", bus8.busy); end
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 8; j++) begin
                send8(rom[i][j]);
                if (i == 6 && j == 6) begin
                    checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL rom_early_done got=%b exp=0", bus8.done); end
                end
            end
        end
        checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL rom_done got=%b exp=1", bus8.done); end
        e = exp_q.pop_front();
        checks++; if (bus8.crc_out !== e[7:0]) begin errors++; $display("FAIL rom_crc got=%h exp=%h", bus8.crc_out, e[7:0]); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rom_busy_end got=%b exp=0", bus8.busy); end
        @(posedge clk); #1;
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL rom_done_width got=%b exp=0", bus8.done); end
        checks++; if (bus8.crc_out !== 8'hA2) begin errors++; $display("FAIL rom_crc_hold got=%h exp=a2", bus8.crc_out); end
        checks++; if (dbg8 !== 2'd0) begin errors++; $display("FAIL rom_idle got=%0d exp=0", dbg8); end
    endtask

    task automatic test_residue();
        logic [15:0] e;
        logic [15:0] m;
        logic        b;
        for (int pass = 0; pass < 2; pass++) begin
            m = 16'h0000;
            start8(16'd64);
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    b = rom[i][j];
                    if (pass == 1 && i == 7 && j == 7) b = ~b;
                    m = crc_step(m, b, 16'h008C);
                    if (i == 7 && j == 7) exp_q.push_back(m);
                    send8(b);
                end
            end
            checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL residue_done pass=%0d got=%b exp=1", pass, bus8.done); end
            e = exp_q.pop_front();
            checks++; if (bus8.crc_out !== e[7:0]) begin errors++; $display("FAIL residue_crc pass=%0d got=%h exp=%h", pass, bus8.crc_out, e[7:0]); end
            if (pass == 0) begin
                checks++; if (bus8.crc_out !== 8'h00) begin errors++; $display("FAIL residue_zero got=%h exp=00", bus8.crc_out); end
                checks++; if (bus8.crc_ok !== OK_EN) begin errors++; $display("FAIL residue_ok got=%b exp=%b", bus8.crc_ok, OK_EN); end
            end else begin
                checks++; if (bus8.crc_ok !== 1'b0) begin errors++; $display("FAIL residue_flip_ok got=%b exp=0", bus8.crc_ok); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_crc16_gaps();
        logic [15:0] e;
        // "123456789" then its transmitted CRC-16 (C2 44 on the wire).
        for (int pass = 0; pass < 2; pass++) begin
            int nbytes;
            nbytes = (pass == 0) ? 9 : 11;
            exp_q.push_back((pass == 0) ? 16'h44C2 : (16'hB001 ^ 16'hFFFF));
            start16(16'(nbytes * 8));
            checks++; if (bus16.busy !== 1'b1) begin errors++; $display("FAIL crc16_busy pass=%0d got=%b exp=1", pass, bus16.busy); end
            for (int i = 0; i < nbytes; i++)
                for (int j = 0; j < 8; j++)
                    send16(str[i][j], $urandom_range(0, 3));
            checks++; if (bus16.done !== 1'b1) begin errors++; $display("FAIL crc16_done pass=%0d got=%b exp=1", pass, bus16.done); end
            e = exp_q.pop_front();
            checks++; if (bus16.crc_out !== e) begin errors++; $display("FAIL crc16_crc pass=%0d got=%h exp=%h", pass, bus16.crc_out, e); end
            if (pass == 1) begin
                checks++; if (bus16.crc_ok !== OK_EN) begin errors++; $display("FAIL crc16_ok got=%b exp=%b", bus16.crc_ok, OK_EN); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        logic [15:0] m;
        logic [15:0] e;
        int          done_seen;
        m = 16'h0000;
        start8(16'd56);
        for (int k = 0; k < 20; k++) begin
            m = crc_step(m, rom[k/8][k%8], 16'h008C);
            send8(rom[k/8][k%8]);
        end
        // abort together with a valid bit: the bit must not be absorbed.
        bus8.abort = 1'b1; bus8.bit_valid = 1'b1; bus8.bit_in = ~m[0];
        @(posedge clk); #1;
        bus8.abort = 1'b0; bus8.bit_valid = 1'b0;
        checks++; if (dbg8 !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", dbg8); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus8.busy); end
        checks++; if (bus8.crc_out !== m[7:0]) begin errors++; $display("FAIL abort_crc got=%h exp=%h", bus8.crc_out, m[7:0]); end
        // bit_valid in IDLE is ignored; no done may appear.
        done_seen = (bus8.done === 1'b1) ? 1 : 0;
        repeat (3) begin
            bus8.bit_valid = 1'b1; bus8.bit_in = 1'b1;
            @(posedge clk); #1;
            if (bus8.done === 1'b1) done_seen++;
        end
        bus8.bit_valid = 1'b0;
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
        checks++; if (bus8.crc_out !== m[7:0]) begin errors++; $display("FAIL idle_bits_ignored got=%h exp=%h", bus8.crc_out, m[7:0]); end
        exp_q.push_back(16'h0000);
        start8(16'd0);
        checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL zero_len_done got=%b exp=1", bus8.done); end
        e = exp_q.pop_front();
        checks++; if (bus8.crc_out !== e[7:0]) begin errors++; $display("FAIL zero_len_crc got=%h exp=%h", bus8.crc_out, e[7:0]); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy got=%b exp=0", bus8.busy); end
        @(posedge clk); #1;
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL zero_len_pulse got=%b exp=0", bus8.done); end
    endtask

    task automatic test_async_reset();
        logic [15:0] m;
        logic [15:0] e;
        int          done_seen;
        start8(16'd56);
        for (int k = 0; k < 10; k++) send8(rom[k/8][k%8]);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", bus8.busy); end
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL areset_done got=%b exp=0", bus8.done); end
        checks++; if (bus8.crc_out !== 8'h00) begin errors++; $display("FAIL areset_crc8 got=%h exp=00", bus8.crc_out); end
        checks++; if (dbg8 !== 2'd0) begin errors++; $display("FAIL areset_state got=%0d exp=0", dbg8); end
        checks++; if (bus16.crc_out !== 16'hFFFF) begin errors++; $display("FAIL areset_crc16 got=%h exp=ffff", bus16.crc_out); end
        #2 rst_n = 1'b1;
        done_seen = 0;
        repeat (4) begin
            bus8.bit_valid = 1'b1; bus8.bit_in = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (bus8.done === 1'b1) done_seen++;
        end
        bus8.bit_valid = 1'b0;
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL areset_no_done got=%0d exp=0", done_seen); end
        m = 16'h0000;
        for (int j = 0; j < 8; j++) m = crc_step(m, rom[1][j], 16'h008C);
        exp_q.push_back(m);
        start8(16'd8);
        for (int j = 0; j < 8; j++) send8(rom[1][j]);
        e = exp_q.pop_front();
        checks++; if (bus8.done !== 1'b1 || bus8.crc_out !== e[7:0]) begin errors++; $display("FAIL areset_resume got=%b/%h exp=1/%h", bus8.done, bus8.crc_out, e[7:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_restart_finish();
        logic [15:0] m;
        logic [15:0] e;
        m = 16'h0000;
        for (int j = 0; j < 8; j++) m = crc_step(m, rom[2][j], 16'h008C);
        exp_q.push_back(m);
        start8(16'd8);
        for (int j = 0; j < 8; j++) send8(rom[2][j]);
        checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL restart_done got=%b exp=1", bus8.done); end
        e = exp_q.pop_front();
        checks++; if (bus8.crc_out !== e[7:0]) begin errors++; $display("FAIL restart_first_crc got=%h exp=%h", bus8.crc_out, e[7:0]); end
        // start during the FINISH cycle
        start8(16'd8);
        checks++; if (dbg8 !== 2'd1) begin errors++; $display("FAIL restart_state got=%0d exp=1", dbg8); end
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b exp=1", bus8.busy); end
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL restart_single_pulse got=%b exp=0", bus8.done); end
        checks++; if (bus8.crc_out !== 8'h00) begin errors++; $display("FAIL restart_init got=%h exp=00", bus8.crc_out); end
        m = 16'h0000;
        for (int j = 0; j < 8; j++) m = crc_step(m, rom[0][j], 16'h008C);
        exp_q.push_back(m);
        for (int j = 0; j < 8; j++) send8(rom[0][j]);
        e = exp_q.pop_front();
        checks++; if (bus8.done !== 1'b1 || bus8.crc_out !== e[7:0]) begin errors++; $display("FAIL restart_second got=%b/%h exp=1/%h", bus8.done, bus8.crc_out, e[7:0]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] m;
        logic [15:0] e;
        logic        bits [0:31];
        int          n;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 24);
            m = 16'h0000;
            for (int k = 0; k < n; k++) begin
                bits[k] = 1'($urandom_range(0, 1));
                m = crc_step(m, bits[k], 16'h008C);
            end
            exp_q.push_back(m);
            start8(16'(n));
            for (int k = 0; k < n; k++) send8(bits[k]);
            e = exp_q.pop_front();
            checks++; if (bus8.done !== 1'b1 || bus8.crc_out !== e[7:0]) begin errors++; $display("FAIL b2b run=%0d n=%0d got=%b/%h exp=1/%h", r, n, bus8.done, bus8.crc_out, e[7:0]); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rom[0] = 8'h02; rom[1] = 8'h1C; rom[2] = 8'hB8; rom[3] = 8'h01;
        rom[4] = 8'h00; rom[5] = 8'h00; rom[6] = 8'h00; rom[7] = 8'hA2;
        for (int i = 0; i < 9; i++) str[i] = 8'h31 + 8'(i);
        str[9] = 8'hC2; str[10] = 8'h44;

        test_reset();
        test_rom_crc8();
        test_residue();
        test_crc16_gaps();
        test_abort();
        test_async_reset();
        test_restart_finish();
        test_back_to_back();

        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
